// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak-f[1600] types, rho offsets and lane helpers
// No ports; imported by keccak_round, keccak_round_constants_gen and keccak_perm_stream.
package keccak_pkg;
  localparam int NUM_LANES = 25;
  // state[y][x] holds lane A[x][y]; stream beat k maps to y=k/5, x=k%5
  typedef logic [4:0][4:0][63:0] state_t;
  typedef enum logic [1:0] {LOAD, PERMUTE, UNLOAD} fsm_t;
  // rho rotation amounts indexed by 5*y+x
  localparam int RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14};
  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return n == 0 ? v : (v << n) | (v >> (64 - n));
  endfunction
  // compressed round constant: bit j lands on lane bit 2^j-1
  function automatic logic [63:0] rc_expand(input logic [6:0] rc);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 7; j++) r[(1 << j) - 1] = rc[j];
    return r;
  endfunction
endpackage

// File: rtl/keccak_round.sv
// keccak_round: one combinational Keccak-f[1600] round (theta, rho, pi, chi, iota)
// Ports: state_in (state before round), rc (compressed round constant), state_out (state after round).
module keccak_round
  import keccak_pkg::*;
(
  input  state_t     state_in,
  input  logic [7:0] rc,
  output state_t     state_out
);
  logic [4:0][63:0] c, d;
  state_t b;
  logic unused_rc;
  assign unused_rc = rc[7];
  for (genvar x = 0; x < 5; x++) begin : g_col
    assign c[x] = state_in[0][x] ^ state_in[1][x] ^ state_in[2][x] ^ state_in[3][x] ^ state_in[4][x];
    assign d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
    for (genvar y = 0; y < 5; y++) begin : g_row
      // rho+pi: A[x][y] rotated lands at B[y][(2x+3y)%5]
      assign b[(2 * x + 3 * y) % 5][y] = rotl(state_in[y][x] ^ d[x], RHO[5 * y + x]);
      assign state_out[y][x] = b[y][x] ^ (~b[y][(x + 1) % 5] & b[y][(x + 2) % 5])
                             ^ ((x == 0 && y == 0) ? rc_expand(rc[6:0]) : 64'd0);
    end
  end
endmodule

// File: rtl/keccak_round_constants_gen.sv
// keccak_round_constants_gen: compressed 8-bit iota constant per round index
// Ports: round (5-bit round index, 24..31 give 0), rc (bit j -> lane bit 2^j-1, bit 7 always 0).
module keccak_round_constants_gen (
  input  logic [4:0] round,
  output logic [7:0] rc
);
  localparam logic [7:0] RC_TAB [32] = '{
    8'h01, 8'h1A, 8'h5E, 8'h70, 8'h1F, 8'h21, 8'h79, 8'h55,
    8'h0E, 8'h0C, 8'h35, 8'h26, 8'h3F, 8'h4F, 8'h5D, 8'h53,
    8'h52, 8'h48, 8'h16, 8'h66, 8'h79, 8'h58, 8'h21, 8'h74,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  assign rc = RC_TAB[round];
endmodule

// File: rtl/keccak_perm_stream.sv
// keccak_perm_stream: lane-streaming Keccak-f[1600] engine, one round per clock
// Ports: clk, rst (async active-high); in_valid/in_ready/in_lane load 25 lanes;
// out_valid/out_ready/out_lane unload 25 permuted lanes; busy high in PERMUTE or UNLOAD.
module keccak_perm_stream
  import keccak_pkg::*;
#(
  parameter int LANE_W     = 64,
  parameter int NUM_ROUNDS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane,
  output logic              busy
);
  state_t st, rnd;
  fsm_t fsm, fsm_nxt;
  logic [4:0] lane_cnt, round_cnt;
  logic [2:0] row, col;
  logic [7:0] rc;
  logic in_fire, out_fire, last_lane, last_round;
  assign in_fire    = in_valid && fsm == LOAD;
  assign out_fire   = out_ready && fsm == UNLOAD;
  assign last_lane  = lane_cnt == 5'(NUM_LANES - 1);
  assign last_round = round_cnt == 5'(NUM_ROUNDS - 1);
  keccak_round_constants_gen u_rc (.round(round_cnt), .rc(rc));
  keccak_round u_round (.state_in(st), .rc(rc), .state_out(rnd));
  always_ff @(posedge clk or posedge rst)
    if (rst) fsm <= LOAD;
    else     fsm <= fsm_nxt;
  always_comb begin
    in_ready  = fsm == LOAD;
    out_valid = fsm == UNLOAD;
    busy      = fsm != LOAD;
    out_lane  = fsm == UNLOAD ? st[row][col] : '0;
    fsm_nxt   = (in_fire && last_lane)          ? PERMUTE :
                (fsm == PERMUTE && last_round)  ? UNLOAD  :
                (out_fire && last_lane)         ? LOAD    : fsm;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= '0;
      lane_cnt  <= '0;
      round_cnt <= '0;
      row       <= '0;
      col       <= '0;
    end else begin
      if (in_fire) st[row][col] <= in_lane;
      if (fsm == PERMUTE) begin
        st        <= rnd;
        round_cnt <= last_round ? 5'd0 : round_cnt + 5'd1;
      end
      // row/col track lane_cnt as (lane_cnt/5, lane_cnt%5) without a divider
      if (in_fire || out_fire) begin
        lane_cnt <= last_lane ? 5'd0 : lane_cnt + 5'd1;
        col      <= col == 3'd4 ? 3'd0 : col + 3'd1;
        row      <= col != 3'd4 ? row : row == 3'd4 ? 3'd0 : row + 3'd1;
      end
    end
  end
endmodule
